// File: rtl/mem_store_buffer.sv
// rtl/mem_store_buffer.sv - posted-write store buffer with load forwarding in front of mem_data
module mem_store_buffer #(
  parameter int p_DEPTH         = 4,
  parameter int p_DATA_MEM_SIZE = 1024,
  parameter int p_WORD_LEN      = 16,
  parameter int p_ADDR_LEN      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [p_ADDR_LEN-1:0] cpu_addr,
  input  logic [p_WORD_LEN-1:0] cpu_wdata,
  input  logic                  cpu_we,
  input  logic                  cpu_re,
  input  logic                  cpu_flush,
  output logic [p_WORD_LEN-1:0] cpu_rdata,
  output logic                  cpu_stall,
  output logic                  empty,
  output logic [p_ADDR_LEN-1:0] mem_addr,
  output logic [p_WORD_LEN-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [p_WORD_LEN-1:0] mem_rdata
);

  localparam int PTR_W  = $clog2(p_DEPTH);
  localparam int CNT_W  = $clog2(p_DEPTH + 1);
  localparam int MEM_AW = $clog2(p_DATA_MEM_SIZE);

  logic [p_ADDR_LEN-1:0] addr_q [p_DEPTH];
  logic [p_WORD_LEN-1:0] data_q [p_DEPTH];
  logic [p_DEPTH-1:0]    valid_q;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;

  logic                  full;
  logic                  flushing;
  logic                  in_range;
  logic                  load_sel;
  logic                  drain;
  logic                  push;
  logic                  fwd_hit;
  logic [p_WORD_LEN-1:0] fwd_data;

  assign full     = (count == CNT_W'(p_DEPTH));
  assign flushing = cpu_flush && (count != '0);
  assign in_range = (cpu_addr[p_ADDR_LEN-1:MEM_AW] == '0);

  // A load owns the data port unless a flush is draining; then loads wait behind the stall.
  assign load_sel = cpu_re && !flushing;
  assign drain    = !load_sel && (count != '0);

  assign cpu_stall = (cpu_we && full) || flushing;
  assign push      = cpu_we && !cpu_stall && in_range;
  assign empty     = (count == '0);

  assign mem_we    = drain;
  assign mem_addr  = drain ? addr_q[head] : cpu_addr;
  assign mem_wdata = drain ? data_q[head] : '0;

  // Walk oldest to youngest so the last match is the youngest pending store.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < p_DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (valid_q[idx] && (addr_q[idx] == cpu_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  assign cpu_rdata = (cpu_re && !cpu_we) ? (fwd_hit ? fwd_data : mem_rdata) : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= cpu_addr;
      data_q[tail] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      valid_q <= '0;
    end else begin
      if (push) begin
        valid_q[tail] <= 1'b1;
        tail          <= tail + PTR_W'(1);
      end
      if (drain) begin
        valid_q[head] <= 1'b0;
        head          <= head + PTR_W'(1);
      end
      case ({push, drain})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_store_buffer.sv
// tb/tb_mem_store_buffer.sv - scoreboard bench for mem_store_buffer
module tb_mem_store_buffer;

  logic        clk;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_we;
  logic        cpu_re;
  logic        cpu_flush;
  logic [15:0] cpu_rdata;
  logic        cpu_stall;
  logic        empty;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_wr[$];
  logic [15:0] exp_rd[$];
  logic [15:0] mem [0:1023];

  mem_store_buffer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_flush (cpu_flush),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .empty     (empty),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mem_data stand-in: writes on negedge, combinational read, 0 when out of range
  initial for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
  always @(negedge clk) if (mem_we && mem_addr[15:10] == 6'd0) mem[mem_addr[9:0]] <= mem_wdata;
  assign mem_rdata = (mem_addr[15:10] == 6'd0) ? mem[mem_addr[9:0]] : 16'h0000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", mem_addr, mem_wdata);
        end else begin
          logic [31:0] w;
          w = exp_wr.pop_front();
          chk("drain_addr", {16'h0, mem_addr}, {16'h0, w[31:16]});
          chk("drain_data", {16'h0, mem_wdata}, {16'h0, w[15:0]});
        end
      end
      if (cpu_re && !cpu_we && !cpu_stall) begin
        if (exp_rd.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_load: got %0h, expected no load", cpu_rdata);
        end else begin
          chk("load_data", {16'h0, cpu_rdata}, {16'h0, exp_rd.pop_front()});
        end
      end
    end
  end

  task automatic set_in(input logic we, input logic re, input logic fl,
                        input logic [15:0] a, input logic [15:0] d);
    cpu_we    = we;
    cpu_re    = re;
    cpu_flush = fl;
    cpu_addr  = a;
    cpu_wdata = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty();
    set_in(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 20 && !empty; i++) tick();
    chk("drain_done", {31'h0, empty}, 32'h1);
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    #1;
    chk("rst_empty", {31'h0, empty}, 32'h1);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_stall", {31'h0, cpu_stall}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // single store, drain on next idle cycle, then read back from memory
    set_in(1'b1, 1'b0, 1'b0, 16'h0010, 16'hABCD);
    exp_wr.push_back({16'h0010, 16'hABCD});
    tick();
    set_in(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #2;
    chk("t2_mem_we", {31'h0, mem_we}, 32'h1);
    chk("t2_mem_addr", {16'h0, mem_addr}, 32'h0010);
    chk("t2_mem_wdata", {16'h0, mem_wdata}, 32'hABCD);
    tick();
    chk("t2_empty", {31'h0, empty}, 32'h1);
    set_in(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    exp_rd.push_back(16'hABCD);
    tick();

    // fill the queue (load-blocked cycles), then a fifth store waits for a pop
    for (int i = 1; i <= 4; i++) begin
      set_in(1'b1, 1'b1, 1'b0, 16'(i), 16'h1000 + 16'(i));
      exp_wr.push_back({16'(i), 16'h1000 + 16'(i)});
      #2;
      chk("t3_illegal_rdata", {16'h0, cpu_rdata}, 32'h0);
      tick();
    end
    chk("t3_not_empty", {31'h0, empty}, 32'h0);
    set_in(1'b0, 1'b1, 1'b0, 16'h0100, 16'h0000);
    exp_rd.push_back(16'h0000);
    #2;
    chk("t3_load_no_stall", {31'h0, cpu_stall}, 32'h0);
    tick();
    set_in(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000);
    exp_rd.push_back(16'h1003);
    tick();
    set_in(1'b1, 1'b0, 1'b0, 16'h0005, 16'h1005);
    exp_wr.push_back({16'h0005, 16'h1005});
    #2;
    chk("t3_full_stall", {31'h0, cpu_stall}, 32'h1);
    chk("t3_full_drain", {31'h0, mem_we}, 32'h1);
    tick();
    #2;
    chk("t3_accept", {31'h0, cpu_stall}, 32'h0);
    tick();
    wait_empty();

    // same-address stores: youngest forwards, retire in order
    set_in(1'b1, 1'b0, 1'b0, 16'h0020, 16'h1111);
    exp_wr.push_back({16'h0020, 16'h1111});
    tick();
    set_in(1'b1, 1'b0, 1'b0, 16'h0020, 16'h2222);
    exp_wr.push_back({16'h0020, 16'h2222});
    tick();
    set_in(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
    exp_rd.push_back(16'h2222);
    tick();
    wait_empty();
    chk("t4_mem_final", {16'h0, mem[16'h0020]}, 32'h2222);
    set_in(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
    exp_rd.push_back(16'h2222);
    tick();

    // out-of-range store is dropped; out-of-range load returns 0
    set_in(1'b1, 1'b0, 1'b0, 16'h0400, 16'h5555);
    #2;
    chk("t5_no_stall", {31'h0, cpu_stall}, 32'h0);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #2;
    chk("t5_empty", {31'h0, empty}, 32'h1);
    chk("t5_no_write", {31'h0, mem_we}, 32'h0);
    tick();
    set_in(1'b0, 1'b1, 1'b0, 16'h0400, 16'h0000);
    exp_rd.push_back(16'h0000);
    tick();

    // flush drains three entries under stall
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b1, 1'b0, 16'h0030 + 16'(i), 16'h3000 + 16'(i));
      exp_wr.push_back({16'h0030 + 16'(i), 16'h3000 + 16'(i)});
      tick();
    end
    set_in(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("t6_flush_stall", {31'h0, cpu_stall}, (i < 3) ? 32'h1 : 32'h0);
      tick();
    end
    chk("t6_flush_empty", {31'h0, empty}, 32'h1);

    // reset mid-drain discards the remaining entries
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b1, 1'b0, 16'h0040 + 16'(i), 16'h4000 + 16'(i));
      if (i == 0) exp_wr.push_back({16'h0040, 16'h4000});
      tick();
    end
    set_in(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    #1;
    chk("t6_draining", {31'h0, mem_we}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("t6_rst_empty", {31'h0, empty}, 32'h1);
    chk("t6_rst_stall", {31'h0, cpu_stall}, 32'h0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("t6_mem_41", {16'h0, mem[16'h0041]}, 32'h0);

    chk("wr_queue_drained", exp_wr.size(), 32'h0);
    chk("rd_queue_drained", exp_rd.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish, expected finish before 50000");
    $fatal(1);
  end

endmodule
